// File: rtl/map018_pkg.sv
// map018_pkg -- shared definitions for the Jaleco SS88006 (mapper 18) core.
//
// Contents:
//   reg_sel_e    : register-select codes formed as {cpu_addr[14:12], cpu_addr[1:0]}
//   mirror_e     : nametable mirroring modes held in the $F002 register
//   irq_size_e   : IRQ counter width selected by the $F001 size bits
//   MASK_*       : counter field masks for each counter width
//   set_nibble   : replace the low or high nibble of a bank register
//   size_code    : priority-decode the three $F001 size bits
//   size_mask    : counter field mask for a size code
package map018_pkg;

  localparam logic [15:0] MASK_4  = 16'h000F;
  localparam logic [15:0] MASK_8  = 16'h00FF;
  localparam logic [15:0] MASK_12 = 16'h0FFF;
  localparam logic [15:0] MASK_16 = 16'hFFFF;

  typedef enum logic [4:0] {
    REG_PRG0_L   = 5'b000_00,
    REG_PRG0_H   = 5'b000_01,
    REG_PRG1_L   = 5'b000_10,
    REG_PRG1_H   = 5'b000_11,
    REG_PRG2_L   = 5'b001_00,
    REG_PRG2_H   = 5'b001_01,
    REG_RAM_CTL  = 5'b001_10,
    REG_IRQ_LOAD = 5'b111_00,
    REG_IRQ_CTL  = 5'b111_01,
    REG_MIRROR   = 5'b111_10
  } reg_sel_e;

  typedef enum logic [1:0] {
    MIR_HORIZ    = 2'd0,
    MIR_VERT     = 2'd1,
    MIR_SCREEN_A = 2'd2,
    MIR_SCREEN_B = 2'd3
  } mirror_e;

  typedef enum logic [1:0] {
    SIZE_16 = 2'd0,
    SIZE_12 = 2'd1,
    SIZE_8  = 2'd2,
    SIZE_4  = 2'd3
  } irq_size_e;

  function automatic logic [7:0] set_nibble(input logic [7:0] cur,
                                            input logic       hi,
                                            input logic [3:0] nib);
    return hi ? {nib, cur[3:0]} : {cur[7:4], nib};
  endfunction

  // Size bits are $F001[3:1]; the highest set bit wins, none set means 16-bit.
  function automatic irq_size_e size_code(input logic [2:0] size);
    if (size[2])      return SIZE_4;
    else if (size[1]) return SIZE_8;
    else if (size[0]) return SIZE_12;
    else              return SIZE_16;
  endfunction

  function automatic logic [15:0] size_mask(input irq_size_e code);
    case (code)
      SIZE_4:  return MASK_4;
      SIZE_8:  return MASK_8;
      SIZE_12: return MASK_12;
      default: return MASK_16;
    endcase
  endfunction

endpackage

// File: rtl/map018_irq_ctr.sv
// map018_irq_ctr -- size-maskable 16-bit IRQ down-counter for mapper 18.
// Only instantiated when MAP018_IRQ_EN is defined.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : one-clk pulse per CPU M2 falling edge
//   reload_wr   : $F000 write on this tick (counter <- reload, irq cleared)
//   ack_wr      : $F000 or $F001 write on this tick (irq cleared, no decrement)
//   enable      : counting enabled
//   size        : $F001[3:1] counter width select
//   reload      : 16-bit reload value
//   counter     : current count
//   irq         : IRQ request, active-high, held until acknowledged
module map018_irq_ctr
  import map018_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        reload_wr,
  input  logic        ack_wr,
  input  logic        enable,
  input  logic [2:0]  size,
  input  logic [15:0] reload,
  output logic [15:0] counter,
  output logic        irq
);

  logic [15:0] mask;
  logic [15:0] dec_value;
  logic        field_zero;

  // Only the selected low field counts; bits above it are carried through.
  assign mask       = size_mask(size_code(size));
  assign dec_value  = (counter & ~mask) | ((counter - 16'd1) & mask);
  assign field_zero = (counter & mask) == 16'h0000;

  // A register write on the same tick takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= 16'h0000;
      irq     <= 1'b0;
    end else if (tick) begin
      if (reload_wr) begin
        counter <= reload;
        irq     <= 1'b0;
      end else if (ack_wr) begin
        irq     <= 1'b0;
      end else if (enable) begin
        counter <= dec_value;
        if (field_zero) begin
          irq <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/map_018.sv
// map_018 -- Mapper 18 (Jaleco SS88006) core for the EDN8 mapper set.
// Decodes CPU writes into nibble-wide PRG/CHR bank registers, a PRG-RAM
// control register and a mirroring register, and drives PRG/CHR/CIRAM
// addressing. The IRQ counter is built only when MAP018_IRQ_EN is defined;
// otherwise $E000-$F001 writes are ignored and irq is tied low.
//
// Parameters:
//   PRG_BW : PRG ROM address width (default 21)
//   CHR_BW : CHR address width (default 18)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   m2         : CPU M2 phase, already registered in the clk domain
//   cpu_addr   : CPU address
//   cpu_dat    : CPU write data (low nibble used)
//   cpu_rw     : 1 = read, 0 = write
//   ppu_addr   : PPU address
//   prg_addr   : PRG ROM address
//   chr_addr   : CHR address
//   ram_ce     : PRG-RAM select
//   ram_we     : PRG-RAM write permitted
//   ciram_a10  : nametable A10
//   irq        : IRQ request, active-high
module map_018
  import map018_pkg::*;
#(
  parameter int PRG_BW = 21,
  parameter int CHR_BW = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m2,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic              cpu_rw,
  input  logic [13:0]       ppu_addr,
  output logic [PRG_BW-1:0] prg_addr,
  output logic [CHR_BW-1:0] chr_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              ciram_a10,
  output logic              irq
);

  logic        m2_d1;
  logic        tick;
  logic        wr;
  logic [4:0]  sel;
  logic [2:0]  chr_grp;
  logic [2:0]  chr_sel;

  logic [7:0]  prg0;
  logic [7:0]  prg1;
  logic [7:0]  prg2;
  logic [7:0]  chr_bank [8];
  logic [1:0]  ram_ctl;
  mirror_e     mirror;

  logic [7:0]  prg_bank;
  logic [20:0] prg_full;
  logic [17:0] chr_full;
  logic        unused_bits;

`ifdef MAP018_IRQ_EN
  logic [15:0] irq_reload;
  logic        irq_enable;
  logic [2:0]  irq_size;
  logic [15:0] irq_count;
  logic        reload_wr;
  logic        ack_wr;
`endif

  assign tick = m2_d1 & ~m2;
  assign wr   = tick & ~cpu_rw & cpu_addr[15];
  assign sel  = {cpu_addr[14:12], cpu_addr[1:0]};

  // $A000-$D003 hold chr0..chr7 as nibble pairs; addr[1] picks the bank
  // within a page, addr[0] the nibble.
  assign chr_grp = cpu_addr[14:12] - 3'd2;
  assign chr_sel = {chr_grp[1:0], cpu_addr[1]};

  // Register file; m2_d1 resets low so a held-high m2 never fakes a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_d1   <= 1'b0;
      prg0    <= 8'h00;
      prg1    <= 8'h00;
      prg2    <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        chr_bank[i] <= 8'h00;
      end
      ram_ctl <= 2'b00;
      mirror  <= MIR_HORIZ;
`ifdef MAP018_IRQ_EN
      irq_reload <= 16'h0000;
      irq_enable <= 1'b0;
      irq_size   <= 3'b000;
`endif
    end else begin
      m2_d1 <= m2;
      if (wr) begin
        if (cpu_addr[14:12] inside {[3'd2:3'd5]}) begin
          chr_bank[chr_sel] <= set_nibble(chr_bank[chr_sel], cpu_addr[0], cpu_dat[3:0]);
        end else if (cpu_addr[14:12] == 3'd6) begin
`ifdef MAP018_IRQ_EN
          case (cpu_addr[1:0])
            2'd0:    irq_reload[3:0]   <= cpu_dat[3:0];
            2'd1:    irq_reload[7:4]   <= cpu_dat[3:0];
            2'd2:    irq_reload[11:8]  <= cpu_dat[3:0];
            default: irq_reload[15:12] <= cpu_dat[3:0];
          endcase
`endif
        end else begin
          case (sel)
            REG_PRG0_L, REG_PRG0_H: prg0 <= set_nibble(prg0, sel[0], cpu_dat[3:0]);
            REG_PRG1_L, REG_PRG1_H: prg1 <= set_nibble(prg1, sel[0], cpu_dat[3:0]);
            REG_PRG2_L, REG_PRG2_H: prg2 <= set_nibble(prg2, sel[0], cpu_dat[3:0]);
            REG_RAM_CTL:            ram_ctl <= cpu_dat[1:0];
`ifdef MAP018_IRQ_EN
            REG_IRQ_CTL: begin
              irq_enable <= cpu_dat[0];
              irq_size   <= cpu_dat[3:1];
            end
`endif
            REG_MIRROR:             mirror <= mirror_e'(cpu_dat[1:0]);
            default: ;
          endcase
        end
      end
    end
  end

  // The last 8 KB window ($E000-$FFFF) is hard-wired to the final bank.
  always_comb begin
    prg_bank = 8'hFF;
    case (cpu_addr[14:13])
      2'd0:    prg_bank = prg0;
      2'd1:    prg_bank = prg1;
      2'd2:    prg_bank = prg2;
      default: prg_bank = 8'hFF;
    endcase
  end

  assign prg_full = {prg_bank, cpu_addr[12:0]};
  assign prg_addr = PRG_BW'(prg_full);

  assign chr_full = {chr_bank[ppu_addr[12:10]], ppu_addr[9:0]};
  assign chr_addr = CHR_BW'(chr_full);

  always_comb begin
    ciram_a10 = 1'b0;
    case (mirror)
      MIR_HORIZ:    ciram_a10 = ppu_addr[11];
      MIR_VERT:     ciram_a10 = ppu_addr[10];
      MIR_SCREEN_A: ciram_a10 = 1'b0;
      default:      ciram_a10 = 1'b1;
    endcase
  end

  assign ram_ce = ram_ctl[0] & (cpu_addr[15:13] == 3'b011);
  assign ram_we = ram_ce & ram_ctl[1] & ~cpu_rw;

`ifdef MAP018_IRQ_EN
  assign reload_wr = wr & (sel == REG_IRQ_LOAD);
  assign ack_wr    = wr & ((sel == REG_IRQ_LOAD) | (sel == REG_IRQ_CTL));

  map018_irq_ctr u_irq (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .reload_wr (reload_wr),
    .ack_wr    (ack_wr),
    .enable    (irq_enable),
    .size      (irq_size),
    .reload    (irq_reload),
    .counter   (irq_count),
    .irq       (irq)
  );

  assign unused_bits = ^{cpu_dat[7:4], ppu_addr[13], chr_grp[2], irq_count};
`else
  assign irq         = 1'b0;
  assign unused_bits = ^{cpu_dat[7:4], ppu_addr[13], chr_grp[2]};
`endif

endmodule

// File: tb/tb_map_018.sv
// tb_map_018 -- self-checking bench for map_018.
// A behavioural model of the mapper (bank tables, integer counter with a
// modulus per size) is stepped once per CPU bus cycle; a compare process
// checks every DUT output against it on each falling clk edge. Directed
// literal checks pin the model to hand-worked values. Honours MAP018_IRQ_EN.
module tb_map_018;

  logic        clk;
  logic        rst_n;
  logic        m2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic [13:0] ppu_addr;
  logic [20:0] prg_addr;
  logic [17:0] chr_addr;
  logic        ram_ce;
  logic        ram_we;
  logic        ciram_a10;
  logic        irq;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Behavioural model state
  int m_prg [3];
  int m_chr [8];
  int m_ctl, m_mir, m_reload, m_cnt, m_en, m_size, m_irq;

  map_018 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2        (m2),
    .cpu_addr  (cpu_addr),
    .cpu_dat   (cpu_dat),
    .cpu_rw    (cpu_rw),
    .ppu_addr  (ppu_addr),
    .prg_addr  (prg_addr),
    .chr_addr  (chr_addr),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ciram_a10 (ciram_a10),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_prg[i] = 0;
    for (int i = 0; i < 8; i++) m_chr[i] = 0;
    m_ctl = 0; m_mir = 0; m_reload = 0; m_cnt = 0; m_en = 0; m_size = 0; m_irq = 0;
  endfunction

  function automatic int setnib(int v, int sh, int nib);
    return (v & ~(15 << sh)) | (nib << sh);
  endfunction

  function automatic int modulus();
    if ((m_size & 4) != 0) return 16;
    if ((m_size & 2) != 0) return 256;
    if ((m_size & 1) != 0) return 4096;
    return 65536;
  endfunction

  // One CPU bus cycle ending in an M2 fall.
  function automatic void model_cycle(int a, int d, bit rw);
    int region = a >> 12;
    int off    = a & 3;
    int nib    = d & 15;
    int sh     = (off & 1) * 4;
    bit is_wr  = !rw && (a >= 'h8000);
`ifdef MAP018_IRQ_EN
    if (is_wr && region == 15 && off == 0) begin
      m_cnt = m_reload;
      m_irq = 0;
    end else if (is_wr && region == 15 && off == 1) begin
      m_irq = 0;
    end else if (m_en != 0) begin
      int m    = modulus();
      int low  = m_cnt % m;
      int high = m_cnt - low;
      if (low == 0) begin
        low   = m - 1;
        m_irq = 1;
      end else begin
        low = low - 1;
      end
      m_cnt = high + low;
    end
`endif
    if (is_wr) begin
      case (region)
        8: m_prg[off / 2] = setnib(m_prg[off / 2], sh, nib);
        9: begin
          if (off < 2) m_prg[2] = setnib(m_prg[2], sh, nib);
          else if (off == 2) m_ctl = nib & 3;
        end
        10, 11, 12, 13: m_chr[(region - 10) * 2 + off / 2] = setnib(m_chr[(region - 10) * 2 + off / 2], sh, nib);
`ifdef MAP018_IRQ_EN
        14: m_reload = setnib(m_reload, off * 4, nib);
`endif
        15: begin
`ifdef MAP018_IRQ_EN
          if (off == 1) begin
            m_en   = nib & 1;
            m_size = nib >> 1;
          end
`endif
          if (off == 2) m_mir = nib & 3;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic int exp_prg(int a);
    int s    = (a >> 13) & 3;
    int bank = (s == 3) ? 255 : m_prg[s];
    return (bank << 13) | (a & 'h1FFF);
  endfunction

  function automatic int exp_chr(int p);
    return (m_chr[(p >> 10) & 7] << 10) | (p & 'h3FF);
  endfunction

  function automatic int exp_ciram(int p);
    case (m_mir)
      0:       return (p >> 11) & 1;
      1:       return (p >> 10) & 1;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_ram_ce(int a);
    return ((m_ctl & 1) != 0 && ((a >> 13) == 3)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (cpu_addr[15]) checkOutput("prg_addr", 32'(prg_addr), exp_prg(int'(cpu_addr)));
      checkOutput("chr_addr", 32'(chr_addr), exp_chr(int'(ppu_addr)));
      checkOutput("ciram_a10", 32'(ciram_a10), exp_ciram(int'(ppu_addr)));
      checkOutput("ram_ce", 32'(ram_ce), exp_ram_ce(int'(cpu_addr)));
      checkOutput("ram_we", 32'(ram_we),
                  (exp_ram_ce(int'(cpu_addr)) != 0 && (m_ctl & 2) != 0 && !cpu_rw) ? 1 : 0);
      checkOutput("irq", 32'(irq), m_irq);
    end
  end

  // Full bus cycle: m2 high for one clk, then falls; the fall is seen on the
  // following clk edge, after which the model is stepped.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic rw,
                               input logic [13:0] p);
    @(posedge clk); #1;
    cpu_addr = a; cpu_dat = d; cpu_rw = rw; ppu_addr = p; m2 = 1'b1;
    @(posedge clk); #1;
    m2 = 1'b0;
    @(posedge clk); #1;
    model_cycle(int'(a), int'(d), rw);
  endtask

  // Change bus signals without an M2 fall, then settle to the next negedge.
  task automatic setBus(input logic [15:0] a, input logic [7:0] d, input logic rw,
                        input logic [13:0] p);
    @(posedge clk); #1;
    cpu_addr = a; cpu_dat = d; cpu_rw = rw; ppu_addr = p;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(16'h8000, 8'h00, 1'b1, ppu_addr);
  endtask

  initial begin
    logic [15:0] ra;
    int          r;

    rst_n = 1'b0; m2 = 1'b0; cpu_addr = 16'h0000; cpu_dat = 8'h00; cpu_rw = 1'b1;
    ppu_addr = 14'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    $display("[TB] reset released");

    // Reset defaults
    setBus(16'hE123, 8'h00, 1'b1, 14'h0000);
    checkOutput("rst_prg_e123", 32'(prg_addr), {11'd0, 8'hFF, 13'h0123});
    setBus(16'h6000, 8'h00, 1'b0, 14'h0000);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);

    // PRG banking and mirroring
    applyStimulus(16'h8000, 8'h05, 1'b0, 14'h0000);
    applyStimulus(16'h8001, 8'h03, 1'b0, 14'h0000);
    setBus(16'h9ABC, 8'h00, 1'b1, 14'h0000);
    checkOutput("prg_9abc", 32'(prg_addr), {11'd0, 8'h35, 13'h1ABC});
    applyStimulus(16'hF002, 8'h01, 1'b0, 14'h0000);
    setBus(16'h8000, 8'h00, 1'b1, 14'h0400);
    checkOutput("mir_v_a10_hi", 32'(ciram_a10), 32'd1);
    setBus(16'h8000, 8'h00, 1'b1, 14'h0800);
    checkOutput("mir_v_a10_lo", 32'(ciram_a10), 32'd0);

    // CHR banking
    applyStimulus(16'hD002, 8'h0A, 1'b0, 14'h0000);
    applyStimulus(16'hD003, 8'h07, 1'b0, 14'h0000);
    setBus(16'h8000, 8'h00, 1'b1, 14'h1C55);
    checkOutput("chr_1c55", 32'(chr_addr), {14'd0, 8'h7A, 10'h055});

    // PRG-RAM control
    applyStimulus(16'h9002, 8'h03, 1'b0, 14'h0000);
    setBus(16'h7ABC, 8'h00, 1'b0, 14'h0000);
    checkOutput("ram_we_on", 32'(ram_we), 32'd1);

`ifdef MAP018_IRQ_EN
    // 16-bit IRQ: reload 3, wraps on the 4th fall
    applyStimulus(16'hE000, 8'h03, 1'b0, 14'h0000);
    applyStimulus(16'hE001, 8'h00, 1'b0, 14'h0000);
    applyStimulus(16'hE002, 8'h00, 1'b0, 14'h0000);
    applyStimulus(16'hE003, 8'h00, 1'b0, 14'h0000);
    applyStimulus(16'hF000, 8'h00, 1'b0, 14'h0000);
    applyStimulus(16'hF001, 8'h01, 1'b0, 14'h0000);
    idle(3);
    checkOutput("irq16_before", 32'(irq), 32'd0);
    idle(1);
    checkOutput("irq16_set", 32'(irq), 32'd1);
    applyStimulus(16'hF001, 8'h01, 1'b0, 14'h0000);
    checkOutput("irq16_ack", 32'(irq), 32'd0);
    checkOutput("cnt16_ffff", 32'(dut.u_irq.counter), 32'h0000FFFF);

    // 4-bit IRQ: reload 0x1232, upper 12 bits held
    applyStimulus(16'hE000, 8'h02, 1'b0, 14'h0000);
    applyStimulus(16'hE001, 8'h03, 1'b0, 14'h0000);
    applyStimulus(16'hE002, 8'h02, 1'b0, 14'h0000);
    applyStimulus(16'hE003, 8'h01, 1'b0, 14'h0000);
    applyStimulus(16'hF000, 8'h00, 1'b0, 14'h0000);
    applyStimulus(16'hF001, 8'h09, 1'b0, 14'h0000);
    idle(2);
    checkOutput("irq4_before", 32'(irq), 32'd0);
    idle(1);
    checkOutput("irq4_set", 32'(irq), 32'd1);
    checkOutput("cnt4_123f", 32'(dut.u_irq.counter), 32'h0000123F);

    // Same-edge reload wins over the wrapping decrement
    applyStimulus(16'hF001, 8'h09, 1'b0, 14'h0000);
    idle(15);
    checkOutput("cnt4_1230", 32'(dut.u_irq.counter), 32'h00001230);
    applyStimulus(16'hF000, 8'h00, 1'b0, 14'h0000);
    checkOutput("same_edge_irq", 32'(irq), 32'd0);
    checkOutput("same_edge_cnt", 32'(dut.u_irq.counter), 32'h00001232);
    idle(3);
    checkOutput("irq_pre_rst", 32'(irq), 32'd1);
`endif

    // Asynchronous reset mid-operation
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1 checkOutput("async_rst_irq", 32'(irq), 32'd0);
    checkOutput("async_rst_ram_ce", 32'(ram_ce), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized bus traffic
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) ra = 16'h6000 | 16'($urandom_range(0, 'h1FFF));
      else       ra = 16'h8000 | 16'($urandom_range(0, 'h7FFF));
      applyStimulus(ra, 8'($urandom), 1'($urandom), 14'($urandom));
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_018.md
# map_018

Mapper 18 (Jaleco SS88006) core for the EDN8 mapper set. It sits directly upstream of the mapper selection hub as one of the per-mapper sources the hub multiplexes by mapper index. It decodes CPU writes into nibble-wide PRG/CHR bank registers, a PRG-RAM control register and a mirroring register. It runs a 16-bit, CPU-cycle-clocked, size-maskable IRQ down-counter, and produces PRG/CHR/CIRAM addressing and the IRQ request.

## Interface
Parameters:
- PRG_BW, 21: PRG ROM address width (8 KB banks × 256).
- CHR_BW, 18: CHR address width (1 KB banks × 256).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m2  in  1  CPU M2 phase, already registered in the clk domain.
- cpu_addr  in  16  CPU address.
- cpu_dat  in  8  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- ppu_addr  in  14  PPU address.
- prg_addr  out  PRG_BW  PRG ROM address.
- chr_addr  out  CHR_BW  CHR address.
- ram_ce  out  1  PRG-RAM select.
- ram_we  out  1  PRG-RAM write permitted.
- ciram_a10  out  1  nametable A10.
- irq  out  1  IRQ request, active-high (the hub inverts it).

## Operation
- **Write strobe `wr`:** m2 falling edge (m2_d1 & !m2) with cpu_rw=0 and cpu_addr[15]=1.
- **Register select:** {cpu_addr[14:12], cpu_addr[1:0]}. Data is cpu_dat[3:0].
  - Even offset writes the low nibble; odd offset writes the high nibble.
- **PRG banks:**
  - $8000/1 → prg0.
  - $8002/3 → prg1.
  - $9000/1 → prg2.
- **PRG-RAM control, $9002:**
  - bit0 = RAM enable.
  - bit1 = write enable.
- **$9003:** ignored.
- **CHR banks:** $A000–$D003, nibble pairs, chr0..chr7.
  - chrN = (addr[14:12]-2)*2 + addr[1].
- **IRQ reload, $E000–$E003:** reload[3:0], [7:4], [11:8], [15:12].
- **$F000:** counter ← reload; irq ← 0.
- **$F001:**
  - bit0 = enable.
  - bits[3:1] = size; priority 3 > 2 > 1 > 16-bit.
  - Write also sets irq ← 0.
- **$F002:** mirror[1:0].
- **$F003:** ignored.
- **PRG map** (for $8000–$FFFF):
  - prg_addr = {bank, cpu_addr[12:0]}.
  - bank = prg0/prg1/prg2/8'hFF for cpu_addr[14:13] = 0/1/2/3.
- **CHR map:** chr_addr = {chrN, ppu_addr[9:0]}, N = ppu_addr[12:10].
- **ciram_a10 by mirror:**
  - 0 → ppu_addr[11].
  - 1 → ppu_addr[10].
  - 2 → 0.
  - 3 → 1.
- **PRG-RAM:**
  - ram_ce = ctl.bit0 & cpu_addr[15:13] = 3'b011.
  - ram_we = ram_ce & ctl.bit1 & !cpu_rw.
- **IRQ counter:** on each m2 falling edge with enable=1, decrement only the masked field; upper bits hold.
  - Mask field is [3:0], [7:0], [11:0] or [15:0] per size.
  - Masked field 0 → decrement wraps it to all-ones and sets irq ← 1.
  - irq stays set until an ack at $F000 or $F001.
- **Same-edge priority:** a $F000/$F001 write on the same m2 edge as a decrement wins (reload/ack, no decrement, irq ← 0).
- **Disabled counter:** enable=0 freezes the counter; irq holds its value.

## Timing
- **Reset values:**
  - All bank registers, ctl, mirror, reload, counter, enable, size: 0.
  - m2_d1: 0.
  - irq: 0.
- **Outputs immediately after reset:**
  - ram_ce = 0, ram_we = 0.
  - prg_addr = {8'hFF, cpu_addr[12:0]} for the $E000 window, else 0-bank.
- **Register write latency:** register updates on the clk edge that detects the m2 fall. prg_addr/chr_addr/ciram_a10 reflect it combinationally in the next cycle (1 clk latency).
- **irq latency:** irq rises 1 clk after the wrapping m2 fall.
- **Reset mid-operation:** rst_n low clears everything asynchronously, including a pending irq.
- **m2 held across a reset edge:** no spurious strobe, because m2_d1 resets to 0.

## Configuration
- `MAP018_IRQ_EN`:
  - **Defined:** counter, reload, control and irq as above.
  - **Undefined:**
    - Counter/reload/control registers are not synthesized.
    - $E000–$F001 writes are ignored.
    - irq tied to 0.
    - All other behaviour is unchanged.

## Structure
- **Shared package** (map018_pkg): register-select encodings, mirror codes, size codes and the mask constants 16'h000F/00FF/0FFF/FFFF.
- **Sub-module map018_irq_ctr:**
  - Inputs: clk, rst_n, tick (m2 fall), reload_wr, ack_wr, enable, size, reload.
  - Outputs: counter, irq.
  - Instantiated only under MAP018_IRQ_EN.

## Test plan
- **Reset defaults:** after reset, read $E123 → prg_addr = {8'hFF, 13'h0123}; write $6000 → ram_we = 0; irq = 0.
- **PRG banking:** write $8000=5, $8001=3 → access $9ABC gives prg_addr = {8'h35, 13'h1ABC}. Mirror: $F002=1 → ciram_a10 = ppu_addr[10].
- **CHR banking:** write $D002=0xA, $D003=0x7 → ppu_addr 14'h1C55 gives chr_addr = {8'h7A, 10'h055}.
- **16-bit IRQ:** reload = 16'h0003, $F000, $F001=1 → irq sets on the 4th m2 fall. Ack via $F001 → irq = 0; counter now 16'hFFFF.
- **4-bit IRQ:** reload = 16'h1232, $F001=0x9 → after 3 m2 falls irq = 1 and counter = 16'h123F (upper 12 bits held).
- **Same-edge ack and reset:** $F000 write on the wrap edge → irq stays 0, counter = reload. rst_n pulse with irq = 1 → irq = 0 asynchronously.
